// File: rtl/gyms16_boot_sequencer.sv
// Boot and run controller for the GYMS-16 core: streams instruction words
// into instruction memory, holds the core in reset for a fixed time, then
// supervises execution until an error, a halt request or the watchdog.
module gyms16_boot_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RESET_HOLD = 2,
  parameter int unsigned RUN_LIMIT  = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_wdata,
  output logic                  core_reset,
  input  logic                  halt_req,
  input  logic                  error_flag,
  input  logic                  zero_flag,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            halt_cause,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [15:0]           cycle_count,
  output logic                  zero_at_halt
);

  localparam int unsigned WC_W = ADDR_WIDTH + 1;
  localparam int unsigned HW   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic          start_load;
  logic          xfer;
  logic          load_end;
  logic          wdog;
  logic          run_exit;
  logic [1:0]    cause_nx;

  // Handshake and termination qualifiers shared by the FSM and datapath.
  always_comb begin
    start_load = load_start && ((state == S_IDLE) || (state == S_HALT));
    xfer       = (state == S_LOAD) && load_valid && load_ready;
    load_end   = xfer && (load_last || (word_count == WC_W'(DEPTH - 1)));
    wdog       = (cycle_count == 16'(RUN_LIMIT - 1));
  end

  // Next-state logic and run exit cause with fixed priority.
  always_comb begin
    state_nx = state;
    cause_nx = 2'b00;
    run_exit = 1'b0;
    unique case (state)
      S_IDLE: if (load_start) state_nx = S_LOAD;
      S_LOAD: if (load_end) state_nx = S_HOLD;
      S_HOLD: if (hold_cnt == HW'(RESET_HOLD - 1)) state_nx = S_RUN;
      S_RUN: begin
        run_exit = 1'b1;
        if (error_flag)    cause_nx = 2'b01;
        else if (halt_req) cause_nx = 2'b10;
        else if (wdog)     cause_nx = 2'b11;
        else               run_exit = 1'b0;
        if (run_exit) state_nx = S_HALT;
      end
      S_HALT: if (load_start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and state-decoded control outputs, registered from next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      load_ready <= 1'b0;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nx;
      load_ready <= (state_nx == S_LOAD);
      core_reset <= (state_nx == S_RUN);
      busy       <= (state_nx == S_LOAD) || (state_nx == S_HOLD) || (state_nx == S_RUN);
      done       <= (state_nx == S_HALT);
      hold_cnt   <= (state == S_HOLD) ? hold_cnt + HW'(1) : '0;
    end
  end

  // Memory write port: one-cycle write pulse per accepted word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      im_we <= xfer;
      if (start_load) begin
        im_addr <= '0;
      end else if (xfer) begin
        im_addr  <= word_count[ADDR_WIDTH-1:0];
        im_wdata <= load_data;
      end
    end
  end

  // Load/run statistics; cleared on a new load and held through HALT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_count   <= '0;
      cycle_count  <= '0;
      halt_cause   <= '0;
      zero_at_halt <= 1'b0;
    end else if (start_load) begin
      word_count  <= '0;
      cycle_count <= '0;
      halt_cause  <= '0;
    end else begin
      if (xfer) word_count <= word_count + WC_W'(1);
      if (state == S_RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + 16'd1;
        if (run_exit) begin
          halt_cause   <= cause_nx;
          zero_at_halt <= zero_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_gyms16_boot_sequencer.sv
// Scoreboard bench for gyms16_boot_sequencer: stimulus pushes expected
// memory writes and halt statuses; a negedge monitor pops and compares.
module tb_gyms16_boot_sequencer;

  localparam int DW         = 16;
  localparam int AW         = 8;
  localparam int DEPTH      = 256;
  localparam int RESET_HOLD = 2;
  localparam int RUN_LIMIT  = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata;
  logic          core_reset;
  logic          halt_req = 1'b0;
  logic          error_flag = 1'b0;
  logic          zero_flag = 1'b0;
  logic          busy;
  logic          done;
  logic [1:0]    halt_cause;
  logic [AW:0]   word_count;
  logic [15:0]   cycle_count;
  logic          zero_at_halt;

  always #5 clock = ~clock;

  gyms16_boot_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .RESET_HOLD(RESET_HOLD),
    .RUN_LIMIT(RUN_LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .core_reset(core_reset),
    .halt_req(halt_req),
    .error_flag(error_flag),
    .zero_flag(zero_flag),
    .busy(busy),
    .done(done),
    .halt_cause(halt_cause),
    .word_count(word_count),
    .cycle_count(cycle_count),
    .zero_at_halt(zero_at_halt)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int cause;
    int cycles;
    int words;
    int zero;
  } st_t;

  wr_t wr_q[$];
  st_t st_q[$];
  wr_t we_exp;
  st_t se_exp;
  int  vectors = 0;
  int  miscompares = 0;
  int  last_words = 0;
  logic done_prev;
  logic [15:0] dir_words [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each memory write and each HALT entry against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      done_prev = 1'b0;
    end else begin
      if (im_we) begin
        if (wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", im_addr, im_wdata);
        end else begin
          we_exp = wr_q.pop_front();
          check("wr_addr", 32'(im_addr), 32'(we_exp.addr));
          check("wr_data", 32'(im_wdata), 32'(we_exp.data));
        end
      end
      if (done && !done_prev) begin
        if (st_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_halt: cause %0h cycles %0d", halt_cause, cycle_count);
        end else begin
          se_exp = st_q.pop_front();
          check("halt_cause", 32'(halt_cause), 32'(se_exp.cause));
          check("cycle_count", 32'(cycle_count), 32'(se_exp.cycles));
          check("word_count", 32'(word_count), 32'(se_exp.words));
          check("zero_at_halt", 32'(zero_at_halt), 32'(se_exp.zero));
          check("halt_core_reset", 32'(core_reset), 32'd0);
          check("halt_busy", 32'(busy), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  // Start a load and offer n words; the expected writes are those offered while ready.
  task automatic load_words(input int n, input bit use_last, input int p_valid, input bit directed);
    int offered = 0;
    int acc = 0;
    int guard = 0;
    bit v;
    @(negedge clock);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hBAD0;
    load_last  = 1'b0;
    @(negedge clock);
    load_start = 1'b0;
    while (offered < n && guard < 4000) begin
      v = (int'($urandom_range(0, 99)) < p_valid);
      load_valid = v;
      load_data  = directed ? dir_words[offered] : 16'($urandom);
      load_last  = use_last && (offered == n - 1);
      if (v) begin
        if (load_ready) begin
          wr_q.push_back('{acc, int'(load_data)});
          acc++;
        end
        offered++;
      end
      guard++;
      if (offered < n) @(negedge clock);
    end
    last_words = acc;
  endtask

  // Count cycles with the core held in reset after the final word.
  task automatic check_hold();
    int cnt = 0;
    @(negedge clock);
    load_valid = 1'b0;
    load_last  = 1'b0;
    while (!core_reset && cnt < 50) begin
      cnt++;
      @(negedge clock);
    end
    check("hold_cycles", 32'(cnt), 32'(RESET_HOLD));
  endtask

  // Drive the run; the first event (error > halt_req > watchdog) decides the outcome.
  task automatic run_phase(input int err_at, input int hreq_at);
    int stop;
    int cause;
    int r = 0;
    int t = 0;
    bit inj;
    stop = RUN_LIMIT - 1;
    if (hreq_at >= 0 && hreq_at < stop) stop = hreq_at;
    if (err_at >= 0 && err_at < stop) stop = err_at;
    cause = (err_at == stop) ? 1 : (hreq_at == stop) ? 2 : 3;
    inj = (err_at >= 0) || (hreq_at >= 0);
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (!inj) st_q.push_back('{3, RUN_LIMIT, last_words, int'(zero_flag)});
    while (!done && t < 1000) begin
      if (core_reset) begin
        error_flag = (r == err_at);
        halt_req   = (r == hreq_at);
        if (inj) begin
          zero_flag = 1'($urandom_range(0, 1));
          if (r == stop) st_q.push_back('{cause, stop + 1, last_words, int'(zero_flag)});
        end
        r++;
      end
      t++;
      @(negedge clock);
    end
    error_flag = 1'b0;
    halt_req   = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL run_timeout: done %0b after %0d cycles, expected 1", done, t);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int mode;
    int ea;
    int ha;
    dir_words = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};

    // Reset values
    #12;
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", 32'(im_wdata), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_halt_cause", 32'(halt_cause), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_zero_at_halt", 32'(zero_at_halt), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Abort a load after three words with an asynchronous reset
    load_words(3, 1'b0, 100, 1'b0);
    @(negedge clock);
    load_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("abort_load_ready", 32'(load_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_word_count", 32'(word_count), 32'd0);
    check("abort_core_reset", 32'(core_reset), 32'd0);
    check("abort_im_addr", 32'(im_addr), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_load_ready", 32'(load_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Directed four-word program, then watchdog halt
    load_words(4, 1'b1, 100, 1'b1);
    check_hold();
    run_phase(-1, -1);

    // Error and halt request together at cycle 10: error wins
    load_words(8, 1'b1, 100, 1'b0);
    check_hold();
    run_phase(10, 10);

    // Overlong stream: only DEPTH words are written
    load_words(300, 1'b0, 100, 1'b0);
    run_phase(-1, -1);

    // Randomised loads with gappy valid and random run terminations
    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(0, 3));
      ea = -1;
      ha = -1;
      if (mode == 1) ea = int'($urandom_range(0, 120));
      if (mode == 2) ha = int'($urandom_range(0, 120));
      if (mode == 3) begin
        ea = int'($urandom_range(0, 30));
        ha = int'($urandom_range(0, 30));
      end
      load_words(int'($urandom_range(1, 40)), 1'b1, 50, 1'b0);
      check_hold();
      run_phase(ea, ha);
    end

    repeat (4) @(negedge clock);
    check("writes_drained", 32'(wr_q.size()), 32'd0);
    check("halts_drained", 32'(st_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gyms16_boot_sequencer.md
Name: gyms16_boot_sequencer

Overview:
Boot and run controller for the GYMS-16 pipelined core. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into the core's instruction memory. It then holds the core in reset for a fixed number of cycles, releases it, and supervises execution until `error_flag`, a halt request or a cycle watchdog ends the run. It sits between the host/loader side and the processor's `clock`/`reset`/`instruction_memory` write port.

Parameters:
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 8, instruction memory address width
DEPTH, 256, instruction memory depth in words (≤ 2^ADDR_WIDTH)
RESET_HOLD, 2, cycles `core_reset` is held low after loading (≥1)
RUN_LIMIT, 100, maximum core cycles in RUN before watchdog halt (≥1)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
load_start  input  1  pulse: begin a new load, legal in IDLE or HALT
load_valid  input  1  `load_data` valid
load_data  input  DATA_WIDTH  instruction word
load_last  input  1  qualifies the final word when `load_valid` is high
load_ready  output  1  sequencer can accept a word
im_we  output  1  instruction memory write enable
im_addr  output  ADDR_WIDTH  instruction memory write address
im_wdata  output  DATA_WIDTH  instruction memory write data
core_reset  output  1  active-low reset to the processor
halt_req  input  1  request to stop the core
error_flag  input  1  processor error flag
zero_flag  input  1  processor zero flag, sampled at halt
busy  output  1  high in LOAD, HOLD and RUN
done  output  1  high in HALT
halt_cause  output  2  00 none, 01 error, 10 halt_req, 11 watchdog
word_count  output  ADDR_WIDTH+1  words loaded in the last load
cycle_count  output  16  core cycles executed in the last run
zero_at_halt  output  1  `zero_flag` captured on entry to HALT

Behaviour:
- Reset (async, `reset` = 0) sets:
  - state IDLE, `load_ready` = 0, `im_we` = 0, `im_addr` = 0, `im_wdata` = 0
  - `core_reset` = 0, `busy` = 0, `done` = 0, `halt_cause` = 00
  - `word_count` = 0, `cycle_count` = 0, `zero_at_halt` = 0
- Reset deassertion is treated as synchronous to `clock`. Reset mid-operation aborts everything immediately and the core stays in reset.
- FSM states: IDLE, LOAD, HOLD, RUN, HALT.
- IDLE: `core_reset` = 0. `load_start` → LOAD; clear `word_count`, `cycle_count`, `halt_cause`; `im_addr` ← 0.
- LOAD:
  - `load_ready` = 1 (registered; it is 1 throughout LOAD).
  - A transfer occurs when `load_valid` & `load_ready`. On the next edge: `im_we` = 1, `im_wdata` = `load_data`, `im_addr` = `word_count`, then `word_count` increments.
  - `im_we` is a one-cycle registered pulse, giving write latency 1.
  - On a transfer with `load_last` = 1, or when `word_count` reaches DEPTH: `load_ready` drops the next cycle → HOLD.
  - Further words while not ready are ignored (not written).
  - `load_start` during LOAD is ignored.
- HOLD: `core_reset` = 0 for exactly RESET_HOLD cycles, counted from HOLD entry, then → RUN.
- RUN:
  - `core_reset` = 1; `cycle_count` increments each cycle (saturates at 0xFFFF).
  - Exit priority (highest first): `error_flag` (cause 01), `halt_req` (cause 10), `cycle_count` == RUN_LIMIT−1 (cause 11).
  - On exit → HALT; capture `zero_flag` into `zero_at_halt` on the same edge.
- HALT: `core_reset` = 0, `done` = 1, statuses held. `load_start` → LOAD (new load; clears statuses as in IDLE).
- Simultaneous `load_valid` with `load_start` in IDLE: the word is not accepted (`load_ready` is still 0).
- `load_last` on the DEPTH-th word: the single termination path applies; no duplicate write.
- `busy` and `done` are registered from the state.

Test Plan:
- Reset mid-LOAD after 3 words → all outputs at reset values immediately; `core_reset` = 0; after release the FSM is in IDLE.
- `load_start`, then 4 words 0x1234, 0xABCD, 0x0001, 0xFFFF with `load_last` on the 4th → writes to addresses 0–3 with those values; `word_count` = 4; `core_reset` low for 2 cycles, then high.
- Continue the run with no stimulus → HALT after exactly 100 RUN cycles; `halt_cause` = 11; `cycle_count` = 100; `done` = 1.
- In RUN at cycle 10, pulse `error_flag` and `halt_req` together → `halt_cause` = 01; `cycle_count` = 11; `zero_at_halt` = `zero_flag` value at that edge.
- Stream 300 words with DEPTH = 256 → exactly 256 writes (addresses 0–255); `load_ready` falls after the 256th; the extra 44 words are not written.
- Toggle `load_valid` at random while `load_ready` = 1 → only handshaked words are written, with contiguous addresses and no gaps or duplicates.
